// File: rtl/punc_controller.sv
// Control FSM for the PUnC LC3 processor: decodes ir into per-cycle datapath strobes and selects.
// Define PUNC_ILLEGAL_HALT_EN to halt on opcodes 8/D; otherwise they execute as NOPs.
module punc_controller #(
  parameter int unsigned MEM_RD_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        br_taken,
  output logic        ir_ld,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        pc_ld,
  output logic        pc_src,
  output logic [2:0]  mem_raddr_sel,
  output logic        mem_wr_en,
  output logic        mem_waddr_ind,
  output logic        mem_wdata_rf,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [1:0]  rf_wdata_sel,
  output logic [1:0]  alu_sel,
  output logic        alu_b_const,
  output logic [1:0]  sext_sel,
  output logic        cc_en,
  output logic        halted
);

  localparam logic [2:0] StInit   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StExec2  = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [3:0] OpBr   = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpLd   = 4'h2;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpJsr  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpLdr  = 4'h6;
  localparam logic [3:0] OpStr  = 4'h7;
  localparam logic [3:0] OpRti  = 4'h8;
  localparam logic [3:0] OpNot  = 4'h9;
  localparam logic [3:0] OpLdi  = 4'hA;
  localparam logic [3:0] OpSti  = 4'hB;
  localparam logic [3:0] OpJmp  = 4'hC;
  localparam logic [3:0] OpRsv  = 4'hD;
  localparam logic [3:0] OpLea  = 4'hE;
  localparam logic [3:0] OpTrap = 4'hF;

  localparam logic [2:0] LatMax = 3'(MEM_RD_LAT);

  logic [2:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       lat_done;
  logic [3:0] op;
  logic [2:0] rd, ra;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign rd        = ir[11:9];
  assign ra        = ir[8:6];
  assign lat_done  = (wait_q == LatMax);
  assign unused_ir = ^ir[4:3];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   state_d = StFetch;
      StFetch:  if (lat_done) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        case (op)
          OpLd, OpLdr: state_d = lat_done ? StFetch : StExec;
          OpLdi:       state_d = lat_done ? StExec2 : StExec;
          OpSti:       state_d = StExec2;
          OpTrap:      state_d = StHalt;
`ifdef PUNC_ILLEGAL_HALT_EN
          OpRti, OpRsv: state_d = StHalt;
`else
          OpRti, OpRsv: state_d = StFetch;
`endif
          default:     state_d = StFetch;
        endcase
      end
      StExec2: begin
        if (op != OpLdi || lat_done) state_d = StFetch;
      end
      StHalt:   state_d = StHalt;
      default:  state_d = StInit;
    endcase
  end

  // Counter restarts on every state change so each wait phase sees a fresh count.
  always_comb begin
    if (state_d != state_q) begin
      wait_d = 3'd0;
    end else if (lat_done) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    ir_ld         = 1'b0;
    pc_clr        = 1'b0;
    pc_up         = 1'b0;
    pc_ld         = 1'b0;
    pc_src        = 1'b0;
    mem_raddr_sel = 3'd0;
    mem_wr_en     = 1'b0;
    mem_waddr_ind = 1'b0;
    mem_wdata_rf  = 1'b0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = 3'd0;
    rf_r_addr_0   = 3'd0;
    rf_r_addr_1   = 3'd0;
    rf_wdata_sel  = 2'd0;
    alu_sel       = 2'd0;
    alu_b_const   = 1'b0;
    sext_sel      = 2'd0;
    cc_en         = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        StInit: pc_clr = 1'b1;
        StFetch: begin
          ir_ld = lat_done;
          pc_up = lat_done;
        end
        StExec: begin
          case (op)
            OpAdd, OpAnd: begin
              rf_wr_en    = 1'b1;
              cc_en       = 1'b1;
              rf_wr_addr  = rd;
              rf_r_addr_0 = ra;
              rf_r_addr_1 = ir[2:0];
              alu_sel     = (op == OpAdd) ? 2'd1 : 2'd2;
              alu_b_const = ir[5];
            end
            OpNot: begin
              rf_wr_en    = 1'b1;
              cc_en       = 1'b1;
              rf_wr_addr  = rd;
              rf_r_addr_0 = ra;
              alu_sel     = 2'd3;
            end
            OpLea: begin
              rf_wr_en     = 1'b1;
              rf_wr_addr   = rd;
              rf_wdata_sel = 2'd3;
              sext_sel     = 2'd2;
            end
            OpLd: begin
              mem_raddr_sel = 3'd1;
              sext_sel      = 2'd2;
              rf_wr_addr    = rd;
              rf_wdata_sel  = 2'd2;
              rf_wr_en      = lat_done;
              cc_en         = lat_done;
            end
            OpLdr: begin
              mem_raddr_sel = 3'd4;
              rf_r_addr_0   = ra;
              alu_sel       = 2'd1;
              alu_b_const   = 1'b1;
              sext_sel      = 2'd1;
              rf_wr_addr    = rd;
              rf_wdata_sel  = 2'd2;
              rf_wr_en      = lat_done;
              cc_en         = lat_done;
            end
            OpLdi, OpSti: begin
              mem_raddr_sel = 3'd1;
              sext_sel      = 2'd2;
            end
            OpSt: begin
              mem_wr_en    = 1'b1;
              mem_wdata_rf = 1'b1;
              rf_r_addr_1  = rd;
              sext_sel     = 2'd2;
            end
            OpStr: begin
              mem_wr_en    = 1'b1;
              mem_wdata_rf = 1'b1;
              rf_r_addr_1  = rd;
              rf_r_addr_0  = ra;
              alu_sel      = 2'd1;
              alu_b_const  = 1'b1;
              sext_sel     = 2'd1;
            end
            OpBr: begin
              pc_ld    = br_taken;
              sext_sel = 2'd2;
            end
            OpJmp: begin
              pc_ld       = 1'b1;
              pc_src      = 1'b1;
              rf_r_addr_0 = ra;
            end
            OpJsr: begin
              rf_wr_en     = 1'b1;
              rf_wr_addr   = 3'd7;
              rf_wdata_sel = 2'd1;
              pc_ld        = 1'b1;
              if (ir[11]) begin
                sext_sel = 2'd3;
              end else begin
                pc_src      = 1'b1;
                rf_r_addr_0 = ra;
              end
            end
            default: ;
          endcase
        end
        StExec2: begin
          case (op)
            OpLdi: begin
              mem_raddr_sel = 3'd2;
              rf_wr_addr    = rd;
              rf_wdata_sel  = 2'd2;
              rf_wr_en      = lat_done;
              cc_en         = lat_done;
            end
            OpSti: begin
              mem_wr_en     = 1'b1;
              mem_waddr_ind = 1'b1;
              mem_wdata_rf  = 1'b1;
              rf_r_addr_1   = rd;
            end
            default: ;
          endcase
        end
        StHalt: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
